// File: rtl/hp_pkg.sv
// Shared defaults and arithmetic helpers for the human-presence region result filter.
package hp_pkg;

    localparam int unsigned HP_NUM_REGION = 6;
    localparam int unsigned HP_DW         = 16;
    localparam int unsigned HP_ON_CNT     = 2;
    localparam int unsigned HP_OFF_CNT    = 4;
    localparam int unsigned COMMIT_LAT    = 1;

    // Signed a + b clamped to the range of a w-bit two's-complement value (w <= 32).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        w
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/hp_region_hyst.sv
// Per-region on/off hysteresis: consecutive positive/negative commits set or clear filt.
module hp_region_hyst
    import hp_pkg::*;
#(
    parameter int unsigned ON_CNT  = HP_ON_CNT,
    parameter int unsigned OFF_CNT = HP_OFF_CNT
) (
    input  logic clk,
    input  logic resetn,
    input  logic commit,
    input  logic det,
    input  logic clear,
    output logic filt
);

    localparam int unsigned CNT_MAX = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    logic [CW-1:0] on_cnt;
    logic [CW-1:0] off_cnt;
    logic [CW-1:0] on_nxt_c;
    logic [CW-1:0] off_nxt_c;

    assign on_nxt_c  = (on_cnt == CW'(ON_CNT))   ? on_cnt  : on_cnt + CW'(1);
    assign off_nxt_c = (off_cnt == CW'(OFF_CNT)) ? off_cnt : off_cnt + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            on_cnt  <= '0;
            off_cnt <= '0;
            filt    <= 1'b0;
        end else if (clear) begin
            on_cnt  <= '0;
            off_cnt <= '0;
            filt    <= 1'b0;
        end else if (commit) begin
            if (det) begin
                off_cnt <= '0;
                on_cnt  <= on_nxt_c;
                if (on_nxt_c == CW'(ON_CNT)) begin
                    filt <= 1'b1;
                end
            end else begin
                on_cnt  <= '0;
                off_cnt <= off_nxt_c;
                if (off_nxt_c == CW'(OFF_CNT)) begin
                    filt <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/hp_region_result_filter.sv
// Per-region CNN result filter: burst max scoring, round-robin region pointer,
// hysteresis-filtered detection vector and ML-ready handshake.
module hp_region_result_filter
    import hp_pkg::*;
#(
    parameter int unsigned NUM_REGION = HP_NUM_REGION,
    parameter int unsigned DW         = HP_DW,
    parameter int unsigned ON_CNT     = HP_ON_CNT,
    parameter int unsigned OFF_CNT    = HP_OFF_CNT,
    parameter int unsigned SELW       = $clog2(NUM_REGION)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_rd_done,
    input  logic                   i_rd_rdy,
    input  logic                   i_we,
    input  logic signed [DW-1:0]   i_dout,
    input  logic signed [DW-1:0]   i_offset,
    input  logic signed [DW-1:0]   i_threshold,
    input  logic                   i_filt_en,
    input  logic                   i_clear,
    output logic [SELW-1:0]        o_frame_sel,
    output logic signed [DW-1:0]   o_score,
    output logic [SELW-1:0]        o_score_region,
    output logic                   o_score_vld,
    output logic [NUM_REGION-1:0]  o_det_raw,
    output logic [NUM_REGION-1:0]  o_det_vec,
    output logic                   o_det_any,
    output logic                   o_ml_rdy
);

    logic [1:0]             rd_sr;
    logic                   we_q;
    logic signed [DW-1:0]   max_q;
    logic [SELW-1:0]        burst_region;
    logic signed [DW-1:0]   samp_c;
    logic                   burst_start_c;
    logic                   burst_run_c;
    logic                   burst_end_c;
    logic                   det_c;
    logic [NUM_REGION-1:0]  hit_c;
    logic [NUM_REGION-1:0]  filt;

    assign samp_c        = DW'(sat_add(32'(i_dout), 32'(i_offset), DW));
    assign burst_start_c = i_we & ~we_q;
    assign burst_run_c   = i_we & we_q;
    assign burst_end_c   = ~i_we & we_q;
    assign det_c         = (max_q > i_threshold);

    // One-hot of the region receiving this cycle's commit.
    always_comb begin
        hit_c = '0;
        for (int unsigned r = 0; r < NUM_REGION; r++) begin
            hit_c[r] = burst_end_c && (burst_region == SELW'(r));
        end
    end

    // Region pointer advances on a falling edge of the twice-registered read-done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_sr       <= '0;
            o_frame_sel <= '0;
        end else begin
            rd_sr <= {rd_sr[0], i_rd_done};
            if (rd_sr == 2'b10) begin
                o_frame_sel <= (o_frame_sel == SELW'(NUM_REGION - 1)) ? '0 : o_frame_sel + SELW'(1);
            end
        end
    end

    // Running max of the current burst, latched against the region it started in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q         <= 1'b0;
            max_q        <= '0;
            burst_region <= '0;
        end else begin
            we_q <= i_we;
            if (i_clear) begin
                max_q <= '0;
            end else if (burst_start_c) begin
                max_q <= samp_c;
            end else if (burst_run_c && (samp_c > max_q)) begin
                max_q <= samp_c;
            end
            if (burst_start_c) begin
                burst_region <= o_frame_sel;
            end
        end
    end

    // Commit strobe, score, raw decisions, output selection and ready handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_score_vld    <= 1'b0;
            o_score        <= '0;
            o_score_region <= '0;
            o_det_raw      <= '0;
            o_det_vec      <= '0;
            o_det_any      <= 1'b0;
            o_ml_rdy       <= 1'b1;
        end else begin
            o_score_vld <= burst_end_c;
            if (burst_end_c) begin
                o_score        <= max_q;
                o_score_region <= burst_region;
            end
            for (int unsigned r = 0; r < NUM_REGION; r++) begin
                if (i_clear) begin
                    o_det_raw[r] <= 1'b0;
                end else if (hit_c[r]) begin
                    o_det_raw[r] <= det_c;
                end
            end
            o_det_vec <= i_filt_en ? filt : o_det_raw;
            o_det_any <= |o_det_vec;
            if (burst_end_c) begin
                o_ml_rdy <= 1'b1;
            end else if (!i_rd_rdy) begin
                o_ml_rdy <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGION; g++) begin : g_hyst
        hp_region_hyst #(
            .ON_CNT  (ON_CNT),
            .OFF_CNT (OFF_CNT)
        ) u_hyst (
            .clk    (clk),
            .resetn (resetn),
            .commit (hit_c[g]),
            .det    (det_c),
            .clear  (i_clear),
            .filt   (filt[g])
        );
    end

endmodule

// File: tb/tb_hp_region_result_filter.sv
// Randomized + directed bench for hp_region_result_filter against an event-level model.
module tb_hp_region_result_filter;
    import hp_pkg::*;

    localparam int unsigned NR   = HP_NUM_REGION;
    localparam int unsigned DW   = HP_DW;
    localparam int unsigned SELW = $clog2(NR);
    localparam int          ON   = HP_ON_CNT;
    localparam int          OFF  = HP_OFF_CNT;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 rd_done, rd_rdy, we, filt_en, clear;
    logic signed [DW-1:0] dout, offset, thr;

    logic [SELW-1:0]      o_frame_sel;
    logic signed [DW-1:0] o_score;
    logic [SELW-1:0]      o_score_region;
    logic                 o_score_vld;
    logic [NR-1:0]        o_det_raw, o_det_vec;
    logic                 o_det_any, o_ml_rdy;

    hp_region_result_filter dut (
        .clk(clk), .resetn(resetn), .i_rd_done(rd_done), .i_rd_rdy(rd_rdy),
        .i_we(we), .i_dout(dout), .i_offset(offset), .i_threshold(thr),
        .i_filt_en(filt_en), .i_clear(clear),
        .o_frame_sel(o_frame_sel), .o_score(o_score), .o_score_region(o_score_region),
        .o_score_vld(o_score_vld), .o_det_raw(o_det_raw), .o_det_vec(o_det_vec),
        .o_det_any(o_det_any), .o_ml_rdy(o_ml_rdy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Model state, described per frame event rather than per register.
    int            m_ptr, m_max, m_breg, m_score, m_sreg;
    bit            m_h0, m_h1, m_we, m_vld, m_any, m_rdy;
    bit            m_raw[NR], m_filt[NR];
    int            m_on[NR], m_off[NR];
    logic [NR-1:0] m_vec;

    task automatic m_reset();
        m_ptr = 0; m_max = 0; m_breg = 0; m_score = 0; m_sreg = 0;
        m_h0 = 0; m_h1 = 0; m_we = 0; m_vld = 0; m_any = 0; m_rdy = 1; m_vec = '0;
        for (int r = 0; r < NR; r++) begin
            m_raw[r] = 0; m_filt[r] = 0; m_on[r] = 0; m_off[r] = 0;
        end
    endtask

    function automatic int clamp_sum(input int a, input int b);
        int s, lo, hi;
        s  = a + b;
        hi = (1 <<< (DW - 1)) - 1;
        lo = -(1 <<< (DW - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    function automatic logic [NR-1:0] raw_vec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_raw[r];
        return v;
    endfunction

    task automatic model_step();
        int s, old_ptr;
        bit det;
        logic [NR-1:0] fv;
        if (!resetn) begin
            m_reset();
            return;
        end
        for (int r = 0; r < NR; r++) fv[r] = m_filt[r];
        m_any   = |m_vec;
        m_vec   = filt_en ? fv : raw_vec();
        old_ptr = m_ptr;
        if (m_h1 && !m_h0) m_ptr = (m_ptr + 1) % NR;
        m_h1 = m_h0;
        m_h0 = rd_done;
        s     = clamp_sum(int'(dout), int'(offset));
        m_vld = 0;
        if (we && !m_we) begin
            m_max  = s;
            m_breg = old_ptr;
        end else if (we && m_we) begin
            if (s > m_max) m_max = s;
        end else if (!we && m_we) begin
            m_vld   = 1;
            m_score = m_max;
            m_sreg  = m_breg;
            det     = (m_max > int'(thr));
            if (!clear) begin
                m_raw[m_breg] = det;
                if (det) begin
                    m_off[m_breg] = 0;
                    m_on[m_breg]  = (m_on[m_breg] < ON) ? m_on[m_breg] + 1 : ON;
                    if (m_on[m_breg] == ON) m_filt[m_breg] = 1;
                end else begin
                    m_on[m_breg]  = 0;
                    m_off[m_breg] = (m_off[m_breg] < OFF) ? m_off[m_breg] + 1 : OFF;
                    if (m_off[m_breg] == OFF) m_filt[m_breg] = 0;
                end
            end
        end
        m_we = we;
        if (m_vld) m_rdy = 1;
        else if (!rd_rdy) m_rdy = 0;
        if (clear) begin
            m_max = 0;
            for (int r = 0; r < NR; r++) begin
                m_raw[r] = 0; m_filt[r] = 0; m_on[r] = 0; m_off[r] = 0;
            end
        end
    endtask

    // Every-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("frame_sel",    o_frame_sel,    m_ptr);
            chk("score",        o_score,        m_score);
            chk("score_region", o_score_region, m_sreg);
            chk("score_vld",    o_score_vld,    m_vld);
            chk("det_raw",      o_det_raw,      raw_vec());
            chk("det_vec",      o_det_vec,      m_vec);
            chk("det_any",      o_det_any,      m_any);
            chk("ml_rdy",       o_ml_rdy,       m_rdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic burst(input int n, input int a, input int b = 0, input int c = 0);
        for (int i = 0; i < n; i++) begin
            we   = 1'b1;
            dout = DW'((i == 0) ? a : (i == 1) ? b : c);
            tick();
        end
        we = 1'b0;
        repeat (COMMIT_LAT) tick();
    endtask

    task automatic adv();
        rd_done = 1'b1; tick();
        rd_done = 1'b0; tick();
        tick();
    endtask

    initial begin
        m_reset();
        resetn = 1'b0; rd_done = 1'b0; rd_rdy = 1'b1; we = 1'b0; filt_en = 1'b0; clear = 1'b0;
        dout = '0; offset = '0; thr = '0;
        chk_on = 1'b1;
        tick(); tick();
        chk("rst_ml_rdy", o_ml_rdy, 1);
        chk("rst_det_vec", o_det_vec, 0);
        resetn = 1'b1;
        tick(); tick();

        // Pointer walk 0..5 and wrap to 0
        for (int k = 1; k <= 6; k++) begin
            adv();
            chk("ptr_walk", o_frame_sel, k % 6);
        end

        // Offset saturation and max tracking
        offset = DW'(2800); thr = '0;
        burst(3, -3000, 100, -50);
        chk("t2_max", o_score, 2900);
        chk("t2_vld", o_score_vld, 1);
        chk("t2_raw", o_det_raw, 1);
        burst(1, 32000);
        chk("t2_sat_hi", o_score, 32767);
        offset = DW'(-2800);
        burst(1, -32000);
        chk("t2_sat_lo", o_score, -32768);

        // Hysteresis on region 2
        clear = 1'b1; tick(); clear = 1'b0;
        filt_en = 1'b1; offset = '0; thr = DW'(100);
        adv(); adv();
        burst(1, 500); tick();
        chk("t3_on1", o_det_vec[2], 0);
        burst(1, 500); tick();
        chk("t3_on2", o_det_vec[2], 1);
        chk("t3_any_lag", o_det_any, 0);
        tick();
        chk("t3_any", o_det_any, 1);
        for (int k = 0; k < 3; k++) begin
            burst(1, 0); tick();
            chk("t3_hold", o_det_vec[2], 1);
        end
        burst(1, 0); tick();
        chk("t3_off", o_det_vec[2], 0);

        // Raw mode on region 4
        filt_en = 1'b0;
        adv(); adv();
        burst(1, 500); tick();
        chk("t4_raw_on", o_det_vec[4], 1);
        burst(1, -5); tick();
        chk("t4_raw_off", o_det_vec[4], 0);

        // Ready handshake
        rd_rdy = 1'b0; tick();
        chk("t5_rdy_drop", o_ml_rdy, 0);
        repeat (3) tick();
        chk("t5_rdy_hold", o_ml_rdy, 0);
        burst(2, 7, 8);
        chk("t5_rdy_commit", o_ml_rdy, 1);
        tick();
        chk("t5_rdy_redrop", o_ml_rdy, 0);
        rd_rdy = 1'b1;

        // Burst end coincident with pointer advance 3->4
        repeat (5) adv();
        chk("t6_ptr3", o_frame_sel, 3);
        we = 1'b1; dout = DW'(300); rd_done = 1'b1; tick();
        dout = DW'(200); rd_done = 1'b0; tick();
        we = 1'b0; tick();
        chk("t6_region", o_score_region, 3);
        chk("t6_ptr4", o_frame_sel, 4);
        chk("t6_score", o_score, 300);
        chk("t6_raw", o_det_raw, 8);

        // Clear concurrent with commit
        we = 1'b1; dout = DW'(500); tick();
        we = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        chk("t6_clr_vld", o_score_vld, 1);
        chk("t6_clr_score", o_score, 500);
        chk("t6_clr_raw", o_det_raw, 0);

        // Reset mid-burst abandons the burst
        we = 1'b1; dout = DW'(400); tick(); tick();
        resetn = 1'b0; tick();
        we = 1'b0; tick();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_rst_novld", o_score_vld, 0);
        end
        chk("t6_rst_ptr", o_frame_sel, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (we) we = ($urandom_range(0, 3) != 0);
            else    we = ($urandom_range(0, 2) == 0);
            dout    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000)) - 16'd1000;
            offset  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400)) - 16'd200;
            if (i % 40 == 0) thr = 16'($urandom_range(0, 1600)) - 16'd800;
            if ($urandom_range(0, 3) == 0) rd_done = ~rd_done;
            rd_rdy  = ($urandom_range(0, 3) != 0);
            clear   = ($urandom_range(0, 79) == 0);
            if (i % 60 == 0) filt_en = ~filt_en;
            resetn  = !(i == 400 || i == 401);
            tick();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
